network_mac_pipe: RTL
=====================

NETWORK_MAC_PIPE -- requirements
Module: network_mac_pipe

Interface
REQ-001 SHALL have parameter DIN0_WIDTH, default 16: signed width of din0.
REQ-002 SHALL have parameter DIN1_WIDTH, default 10: signed width of din1.
REQ-003 SHALL have parameter ACC_WIDTH, default 32: accumulator width, SHALL be at least DIN0_WIDTH+DIN1_WIDTH.
REQ-004 SHALL have parameter DOUT_WIDTH, default 16: signed result width.
REQ-005 SHALL have parameter FRAC_SHIFT, default 8: right shift applied to the result, range 0..ACC_WIDTH-1.
REQ-006 SHALL have parameter NUM_STAGE, default 3: accept-to-output latency in cycles, minimum 2.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have port ce, input, 1: global clock enable; when 0 all state holds.
REQ-010 SHALL have port in_valid, input, 1: input beat offered.
REQ-011 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-012 SHALL have port din0, input, DIN0_WIDTH: signed operand A.
REQ-013 SHALL have port din1, input, DIN1_WIDTH: signed operand B.
REQ-014 SHALL have port mode, input, 1: 0 = multiply-only beat, 1 = accumulate beat.
REQ-015 SHALL have port in_last, input, 1: closes the accumulation group (mode=1 beats only).
REQ-016 SHALL have port out_valid, output, 1: result valid.
REQ-017 SHALL have port out_ready, input, 1: downstream accepts when out_valid && out_ready.
REQ-018 SHALL have port dout, output, DOUT_WIDTH: rounded, saturated signed result.
REQ-019 SHALL have port out_sat, output, 1: saturation occurred for this result.

Function
REQ-020 SHALL define adv = ce && (!out_valid || out_ready); in_ready SHALL equal adv (combinational).
REQ-021 SHALL advance all pipeline stages, valid bits and the accumulator only when adv=1; when adv=0 everything, including dout/out_valid, holds.
REQ-022 SHALL register din0, din1, mode, in_last and a valid bit in stage 1, compute full-precision signed product (DIN0_WIDTH+DIN1_WIDTH bits) across stages 2..NUM_STAGE-1, and apply final-stage logic in stage NUM_STAGE (output register).
REQ-023 SHALL, for a mode=0 beat, present f(product sign-extended to ACC_WIDTH) exactly NUM_STAGE adv cycles after acceptance, leaving the accumulator unchanged.
REQ-024 SHALL, for a mode=1 beat with in_last=0, set acc <= sat_ACC(acc + product) and produce no output (out_valid stays/becomes 0 for that slot).
REQ-025 SHALL, for a mode=1 beat with in_last=1, present f(sat_ACC(acc + product)) NUM_STAGE adv cycles after acceptance and clear acc to 0 in the same cycle.
REQ-026 SHALL define f(x): add 2^(FRAC_SHIFT-1) if FRAC_SHIFT>0, arithmetic shift right FRAC_SHIFT, saturate to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]; round-half-up toward +inf.
REQ-027 SHALL set out_sat=1 if output saturation occurred, or for a group result if any accumulator saturation occurred within that group (sticky flag, cleared with acc).
REQ-028 SHALL sustain one accepted beat per cycle when ce=1 and out_ready=1.
REQ-029 SHALL accept mode=0 beats interleaved within an open group without disturbing acc or the sticky flag.
REQ-030 SHALL ignore in_last on mode=0 beats.
REQ-031 SHALL drop a bubble (in_valid=0 during adv) through the pipeline producing no output.

Reset
REQ-032 SHALL, on reset=1 at a clock edge (regardless of ce), clear all valid bits, acc, sticky flag, dout=0, out_sat=0, out_valid=0.
REQ-033 SHALL discard any in-flight beats and any partially accumulated group on reset; operand data registers need not be reset.

Verification
REQ-034 Mode0, din0=1000, din1=-3, continuous ready -> out_valid 3 cycles after accept, dout=-12, out_sat=0.
REQ-035 Mode0, din0=32767, din1=511 -> dout=32767, out_sat=1.
REQ-036 Four mode1 beats din0=256, din1=2, in_last on 4th -> single output dout=8, out_sat=0; acc then 0 (next group of one beat 256x2 -> dout=2).
REQ-037 Output pending with out_ready=0 for 5 cycles -> dout/out_valid stable, in_ready=0, no beat lost or duplicated; streaming resumes at 1 beat/cycle.
REQ-038 Group with 2 mode1 beats accepted, reset pulsed 1 cycle, new group 256x2 last -> dout=2 (old partial sum discarded), no stale out_valid.
REQ-039 ce=0 for 3 cycles mid-stream -> all outputs frozen, in_ready=0; results identical to uninterrupted run.

Source files
------------

// File: rtl/network_mac_pipe.sv
// Pipelined signed multiply / multiply-accumulate with round-half-up, saturation and
// a valid/ready stream interface. One beat per cycle; the whole pipe stalls as a unit.
module network_mac_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 10,
    parameter int ACC_WIDTH  = 32,
    parameter int DOUT_WIDTH = 16,
    parameter int FRAC_SHIFT = 8,
    parameter int NUM_STAGE  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  mode,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_sat
);

    localparam int PW    = DIN0_WIDTH + DIN1_WIDTH;
    localparam int AW    = ACC_WIDTH;
    localparam int DW    = DOUT_WIDTH;
    localparam int DEPTH = NUM_STAGE - 2;

    localparam logic [AW:0]   ONE  = (AW+1)'(1);
    localparam logic [AW:0]   RND  = (ONE << FRAC_SHIFT) >> 1;
    localparam logic [AW:0]   DMAX = (ONE << (DW - 1)) - ONE;
    localparam logic [AW:0]   DMIN = ~DMAX;
    localparam logic [DW-1:0] OMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] OMIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};

    // Handshake: a beat moves on a rising edge when in_valid && in_ready; a result
    // leaves when out_valid && out_ready && ce. Every stage advances together on adv.
    logic adv;
    assign adv      = ce && (!out_valid || out_ready);
    assign in_ready = adv;

    logic                         s1_valid;
    logic                         s1_mode;
    logic                         s1_last;
    logic signed [DIN0_WIDTH-1:0] s1_a;
    logic signed [DIN1_WIDTH-1:0] s1_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_a    <= din0;
            s1_b    <= din1;
            s1_mode <= mode;
            s1_last <= in_last;
        end
    end

    logic signed [PW-1:0] prod_c;
    assign prod_c = $signed({{DIN1_WIDTH{s1_a[DIN0_WIDTH-1]}}, s1_a})
                  * $signed({{DIN0_WIDTH{s1_b[DIN1_WIDTH-1]}}, s1_b});

    logic                 t_valid;
    logic                 t_mode;
    logic                 t_last;
    logic signed [PW-1:0] t_prod;

    generate
        if (DEPTH == 0) begin : g_direct
            assign t_valid = s1_valid;
            assign t_mode  = s1_mode;
            assign t_last  = s1_last;
            assign t_prod  = prod_c;
        end else begin : g_chain
            logic [DEPTH-1:0]     d_valid;
            logic [DEPTH-1:0]     d_mode;
            logic [DEPTH-1:0]     d_last;
            logic signed [PW-1:0] d_prod [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    d_valid <= '0;
                end else if (adv) begin
                    d_valid[0] <= s1_valid;
                    for (int i = 1; i < DEPTH; i++) begin
                        d_valid[i] <= d_valid[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    d_prod[0] <= prod_c;
                    d_mode[0] <= s1_mode;
                    d_last[0] <= s1_last;
                    for (int i = 1; i < DEPTH; i++) begin
                        d_prod[i] <= d_prod[i-1];
                        d_mode[i] <= d_mode[i-1];
                        d_last[i] <= d_last[i-1];
                    end
                end
            end

            assign t_valid = d_valid[DEPTH-1];
            assign t_mode  = d_mode[DEPTH-1];
            assign t_last  = d_last[DEPTH-1];
            assign t_prod  = d_prod[DEPTH-1];
        end
    endgenerate

    logic [AW-1:0]        acc;
    logic                 sticky;
    logic signed [AW-1:0] prod_ext;
    logic [AW:0]          sum_w;
    logic                 acc_ovf;
    logic [AW-1:0]        sum_sat;
    logic [AW-1:0]        x_val;
    logic [AW:0]          rnd_w;
    logic signed [AW:0]   shr;
    logic                 f_hi;
    logic                 f_lo;
    logic                 f_sat;
    logic [DW-1:0]        f_val;

    assign prod_ext = AW'(t_prod);
    assign sum_w    = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};
    assign acc_ovf  = sum_w[AW] ^ sum_w[AW-1];
    assign sum_sat  = acc_ovf ? (sum_w[AW] ? AMIN : AMAX) : sum_w[AW-1:0];
    assign x_val    = t_mode ? sum_sat : prod_ext;

    // One guard bit keeps the rounding add from wrapping near the accumulator limit.
    assign rnd_w = {x_val[AW-1], x_val} + RND;
    assign shr   = $signed(rnd_w) >>> FRAC_SHIFT;
    assign f_hi  = shr > $signed(DMAX);
    assign f_lo  = shr < $signed(DMIN);
    assign f_sat = f_hi || f_lo;
    assign f_val = f_hi ? OMAX : (f_lo ? OMIN : shr[DW-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            dout      <= '0;
            out_sat   <= 1'b0;
            acc       <= '0;
            sticky    <= 1'b0;
        end else if (adv) begin
            out_valid <= t_valid && (!t_mode || t_last);
            if (t_valid) begin
                if (!t_mode) begin
                    dout    <= f_val;
                    out_sat <= f_sat;
                end else if (!t_last) begin
                    acc    <= sum_sat;
                    sticky <= sticky || acc_ovf;
                end else begin
                    dout    <= f_val;
                    out_sat <= f_sat || sticky || acc_ovf;
                    acc     <= '0;
                    sticky  <= 1'b0;
                end
            end
        end
    end

endmodule
